// File: rtl/gray_counter.sv
// Up/down binary counter with a registered Gray-code output, Gray-coded
// parallel load, and single-cycle wrap (tc) and change (chg) strobes.
module gray_counter #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_g,
  output logic [WIDTH-1:0] G,
  output logic             tc,
  output logic             chg
);

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] g_q, g_d;
  logic             tc_q, tc_d;
  logic             chg_q, chg_d;

  // Gray to binary: MSB passes through, each lower bit folds in the bit above.
  function automatic logic [WIDTH-1:0] gray2bin(input logic [WIDTH-1:0] g);
    logic [WIDTH-1:0] b;
    b[WIDTH-1] = g[WIDTH-1];
    for (int i = int'(WIDTH) - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  // Next-state: load beats count beats hold; Gray value derived from next count.
  always_comb begin
    cnt_d = cnt_q;
    tc_d  = 1'b0;
    chg_d = 1'b0;
    if (load) begin
      cnt_d = gray2bin(load_g);
      chg_d = (load_g != g_q);
    end else if (en) begin
      chg_d = 1'b1;
      if (up) begin
        cnt_d = cnt_q + WIDTH'(1);
        tc_d  = &cnt_q;
      end else begin
        cnt_d = cnt_q - WIDTH'(1);
        tc_d  = ~|cnt_q;
      end
    end
    g_d = cnt_d ^ (cnt_d >> 1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      g_q   <= '0;
      tc_q  <= 1'b0;
      chg_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      g_q   <= g_d;
      tc_q  <= tc_d;
      chg_q <= chg_d;
    end
  end

  assign G   = g_q;
  assign tc  = tc_q;
  assign chg = chg_q;

endmodule
